// File: rtl/rca_pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor: the WIDTH-bit carry chain is cut into
// STAGES registered segments, with valid/ready flow control on both sides.
module rca_pipelined_addsub #(
   parameter int WIDTH  = 26,
   parameter int STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_add_term1,
   input  logic [WIDTH-1:0] i_add_term2,
   input  logic             i_carry,
   input  logic             i_sub,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH:0]   o_result,
   output logic             o_overflow
);
   localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;
   localparam int LAST  = STAGES - 1;

   logic [STAGES-1:0] v_all;
   logic [STAGES:0]   rdy;

   // Ready ripples back from the sink; an empty stage always accepts, so bubbles collapse.
   always_comb begin
      rdy         = '0;
      rdy[STAGES] = i_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         rdy[k] = !v_all[k] || rdy[k + 1];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         // Clamped bounds: with uneven splits the trailing segments may be empty.
         localparam int LO = (gi * CHUNK < WIDTH) ? gi * CHUNK : WIDTH;
         localparam int HI = ((gi + 1) * CHUNK < WIDTH) ? (gi + 1) * CHUNK : WIDTH;

         logic             v_in;
         logic [WIDTH-1:0] a_in;
         logic [WIDTH-1:0] b_in;
         logic [WIDTH-1:0] s_in;
         logic             c_in;
         logic             cm_in;
         logic [WIDTH-1:0] s_next;
         logic             c_next;
         logic             cm_next;
         logic             v_reg;
         logic [WIDTH-1:0] s_reg;
         logic             c_reg;
         logic             cm_reg;

         if (gi == 0) begin : g_src
            // Subtract is folded in here: B is inverted and carry-in forced high.
            assign v_in  = i_valid;
            assign a_in  = i_add_term1;
            assign b_in  = i_sub ? ~i_add_term2 : i_add_term2;
            assign s_in  = '0;
            assign c_in  = i_sub | i_carry;
            assign cm_in = 1'b0;
         end else begin : g_src
            assign v_in  = g_stage[gi-1].v_reg;
            assign a_in  = g_stage[gi-1].g_fwd.a_reg;
            assign b_in  = g_stage[gi-1].g_fwd.b_reg;
            assign s_in  = g_stage[gi-1].s_reg;
            assign c_in  = g_stage[gi-1].c_reg;
            assign cm_in = g_stage[gi-1].cm_reg;
         end

         always_comb begin
            s_next  = s_in;
            cm_next = cm_in;
            c_next  = c_in;
            for (int i = LO; i < HI; i++) begin
               if (i == WIDTH - 1) cm_next = c_next;
               s_next[i] = a_in[i] ^ b_in[i] ^ c_next;
               c_next    = (a_in[i] & b_in[i]) | (c_next & (a_in[i] ^ b_in[i]));
            end
         end

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               v_reg  <= 1'b0;
               s_reg  <= '0;
               c_reg  <= 1'b0;
               cm_reg <= 1'b0;
            end else if (rdy[gi]) begin
               v_reg  <= v_in;
               s_reg  <= s_next;
               c_reg  <= c_next;
               cm_reg <= cm_next;
            end
         end

         assign v_all[gi] = v_reg;

         // Operand bits still to be added only need carrying to a following stage.
         if (gi < LAST) begin : g_fwd
            logic [WIDTH-1:0] a_reg;
            logic [WIDTH-1:0] b_reg;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
               if (!i_rst_n) begin
                  a_reg <= '0;
                  b_reg <= '0;
               end else if (rdy[gi]) begin
                  a_reg <= a_in;
                  b_reg <= b_in;
               end
            end
         end
      end
   endgenerate

   assign o_ready    = rdy[0];
   assign o_valid    = g_stage[LAST].v_reg;
   assign o_result   = {g_stage[LAST].c_reg, g_stage[LAST].s_reg};
   assign o_overflow = g_stage[LAST].c_reg ^ g_stage[LAST].cm_reg;

endmodule

// File: tb/tb_rca_pipelined_addsub.sv
// Directed and streaming checks for rca_pipelined_addsub, plus a latency and
// result sweep over several WIDTH/STAGES combinations.
module tb_rca_pipelined_addsub;
   localparam int W = 26;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // main DUT (WIDTH=26, STAGES=2)
   logic         valid = 1'b0;
   logic         rdy;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         ovalid;
   logic         iready = 1'b1;
   logic [W:0]   res;
   logic         ovf;

   rca_pipelined_addsub #(.WIDTH(W), .STAGES(2)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy),
      .i_add_term1(a), .i_add_term2(b), .i_carry(cin), .i_sub(sub),
      .o_valid(ovalid), .i_ready(iready), .o_result(res), .o_overflow(ovf)
   );

   // sweep instances share one stimulus and never stall
   logic         sw_valid = 1'b0;
   logic [W-1:0] sw_a = '0;
   logic [W-1:0] sw_b = '0;
   logic         sw_cin = 1'b0;
   logic         sw_sub = 1'b0;
   logic         sw_v [4];
   logic         sw_o [4];
   logic         sw_rdy [4];
   logic [W:0]   sw_r [3];
   logic [8:0]   r8;

   rca_pipelined_addsub #(.WIDTH(W), .STAGES(1)) dut_s1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(sw_valid), .o_ready(sw_rdy[0]),
      .i_add_term1(sw_a), .i_add_term2(sw_b), .i_carry(sw_cin), .i_sub(sw_sub),
      .o_valid(sw_v[0]), .i_ready(1'b1), .o_result(sw_r[0]), .o_overflow(sw_o[0])
   );
   rca_pipelined_addsub #(.WIDTH(W), .STAGES(3)) dut_s3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(sw_valid), .o_ready(sw_rdy[1]),
      .i_add_term1(sw_a), .i_add_term2(sw_b), .i_carry(sw_cin), .i_sub(sw_sub),
      .o_valid(sw_v[1]), .i_ready(1'b1), .o_result(sw_r[1]), .o_overflow(sw_o[1])
   );
   rca_pipelined_addsub #(.WIDTH(W), .STAGES(26)) dut_s26 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(sw_valid), .o_ready(sw_rdy[2]),
      .i_add_term1(sw_a), .i_add_term2(sw_b), .i_carry(sw_cin), .i_sub(sw_sub),
      .o_valid(sw_v[2]), .i_ready(1'b1), .o_result(sw_r[2]), .o_overflow(sw_o[2])
   );
   rca_pipelined_addsub #(.WIDTH(8), .STAGES(3)) dut_w8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(sw_valid), .o_ready(sw_rdy[3]),
      .i_add_term1(sw_a[7:0]), .i_add_term2(sw_b[7:0]), .i_carry(sw_cin), .i_sub(sw_sub),
      .o_valid(sw_v[3]), .i_ready(1'b1), .o_result(r8), .o_overflow(sw_o[3])
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer arithmetic on w-bit operands, returns {overflow, carry, sum}.
   function automatic logic [W+1:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                          input logic c, input logic s);
      logic [32:0] mask;
      logic [32:0] aa;
      logic [32:0] bb;
      logic [32:0] full;
      logic        ov;
      mask = (33'h1 << w) - 33'h1;
      aa   = {1'b0, av} & mask;
      bb   = (s ? ~{1'b0, bv} : {1'b0, bv}) & mask;
      full = aa + bb + {32'b0, (s | c)};
      ov   = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
      full = full & ((mask << 1) | 33'h1);
      return {ov, full[W:0]};
   endfunction

   // One isolated operation on the main DUT with hand-computed expectations.
   task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                         input logic tc, input logic ts, input logic [W:0] er, input logic eo);
      valid = 1'b1; a = ta; b = tbv; cin = tc; sub = ts; iready = 1'b1;
      #1 check({tag, "/rdy"}, 64'(rdy), 64'd1);
      tick();
      valid = 1'b0; a = '0; b = '0;
      check({tag, "/lat"}, 64'(ovalid), 64'd0);
      tick();
      check({tag, "/valid"}, 64'(ovalid), 64'd1);
      check({tag, "/res"}, 64'(res), 64'(er));
      check({tag, "/ovf"}, 64'(ovf), 64'(eo));
      $display("[TB] %s a=%h b=%h cin=%b sub=%b -> res=%h ovf=%b", tag, ta, tbv, tc, ts, res, ovf);
      tick();
   endtask

   logic [W-1:0] va [6] = '{26'h3FFFFFF, 26'h0000005, 26'h1FFFFFF, 26'h2000000, 26'h2AAAAAA, 26'h1234567};
   logic [W-1:0] vb [6] = '{26'h0000001, 26'h0000007, 26'h0000001, 26'h0000001, 26'h1555555, 26'h0ABCDEF};
   logic         vc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   logic         vs [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   int           stg [4] = '{1, 3, 26, 3};
   int           seen_at [4];
   int           seen_cnt [4];
   logic [W:0]   got_r [4];
   logic         got_o [4];
   logic [W:0]   q_res [$];
   logic         q_ovf [$];
   logic [W+1:0] m;

   initial begin
      // reset state
      #12;
      check("rst/rdy", 64'(rdy), 64'd1);
      check("rst/valid", 64'(ovalid), 64'd0);
      check("rst/res", 64'(res), 64'd0);
      check("rst/ovf", 64'(ovf), 64'd0);
      rst_n = 1'b1;

      // first accept happens on the first edge after release
      run_op("max_add",   26'h3FFFFFF, 26'h0000001, 1'b0, 1'b0, 27'h4000000, 1'b0);
      run_op("sub_borrow", 26'h0000005, 26'h0000007, 1'b0, 1'b1, 27'h3FFFFFE, 1'b0);
      run_op("sub_nobor", 26'h0000007, 26'h0000005, 1'b0, 1'b1, 27'h4000002, 1'b0);
      run_op("ovf_add",   26'h1FFFFFF, 26'h0000001, 1'b0, 1'b0, 27'h2000000, 1'b1);
      run_op("ovf_sub",   26'h2000000, 26'h0000001, 1'b0, 1'b1, 27'h5FFFFFF, 1'b1);
      run_op("cin_add",   26'h0000010, 26'h0000020, 1'b1, 1'b0, 27'h0000031, 1'b0);
      run_op("sub_nocin", 26'h0000010, 26'h0000010, 1'b0, 1'b1, 27'h4000000, 1'b0);
      run_op("seg_carry", 26'h0001FFF, 26'h0000001, 1'b0, 1'b0, 27'h0002000, 1'b0);

      // backpressure: fill with the sink stalled
      iready = 1'b0; valid = 1'b1; a = 26'd1; b = 26'd2; cin = 1'b0; sub = 1'b0;
      #1 check("bp/rdy_empty", 64'(rdy), 64'd1);
      tick();
      a = 26'd10; b = 26'd20;
      #1 check("bp/rdy_one", 64'(rdy), 64'd1);
      check("bp/v_one", 64'(ovalid), 64'd0);
      tick();
      a = 26'h100; b = 26'h200;
      #1 check("bp/rdy_full", 64'(rdy), 64'd0);
      check("bp/res1", 64'(res), 64'h3);
      tick();
      a = 26'h123; b = 26'h321;
      #1 check("bp/hold_rdy", 64'(rdy), 64'd0);
      check("bp/hold_res", 64'(res), 64'h3);
      check("bp/hold_v", 64'(ovalid), 64'd1);
      tick();
      a = 26'h100; b = 26'h200;
      #1 check("bp/hold_res2", 64'(res), 64'h3);
      iready = 1'b1;
      #1 check("bp/collapse", 64'(rdy), 64'd1);
      tick();
      a = 26'h3FFFFFF; b = 26'h3FFFFFF;
      #1 check("bp/res2", 64'(res), 64'h1E);
      check("bp/v2", 64'(ovalid), 64'd1);
      tick();
      valid = 1'b0;
      #1 check("bp/res3", 64'(res), 64'h300);
      tick();
      #1 check("bp/res4", 64'(res), 64'h7FFFFFE);
      check("bp/ovf4", 64'(ovf), 64'd0);
      // stage 0 now holds a bubble: accepting must still be possible with the sink stalled
      iready = 1'b0; valid = 1'b1; a = 26'd5; b = 26'd6;
      #1 check("bp/bubble_rdy", 64'(rdy), 64'd1);
      tick();
      valid = 1'b0;
      #1 check("bp/bubble_full", 64'(rdy), 64'd0);
      check("bp/hold_res4", 64'(res), 64'h7FFFFFE);
      iready = 1'b1;
      tick();
      #1 check("bp/res5", 64'(res), 64'hB);
      check("bp/v5", 64'(ovalid), 64'd1);
      tick();
      #1 check("bp/drained", 64'(ovalid), 64'd0);

      // reset while two operations are in flight
      valid = 1'b1; a = 26'h155; b = 26'h2AA; iready = 1'b1;
      tick();
      a = 26'h0F0; b = 26'h00F;
      tick();
      valid = 1'b0;
      check("mid/pre_v", 64'(ovalid), 64'd1);
      check("mid/pre_res", 64'(res), 64'h3FF);
      #2 rst_n = 1'b0;
      #1 check("mid/v", 64'(ovalid), 64'd0);
      check("mid/res", 64'(res), 64'd0);
      check("mid/ovf", 64'(ovf), 64'd0);
      check("mid/rdy", 64'(rdy), 64'd1);
      tick();
      #2 rst_n = 1'b1;
      for (int n = 0; n < 4; n++) begin
         tick();
         check("mid/no_stale", 64'(ovalid), 64'd0);
      end
      check("mid/rdy_after", 64'(rdy), 64'd1);

      // random stream with random backpressure against a scoreboard
      for (int cyc = 0; cyc < 400; cyc++) begin
         valid  = ($urandom_range(0, 9) < 6);
         iready = ($urandom_range(0, 9) < 6);
         a = W'($urandom);
         b = W'($urandom);
         {cin, sub} = 2'($urandom);
         #1;
         if (valid && rdy) begin
            m = model(W, 32'(a), 32'(b), cin, sub);
            q_res.push_back(m[W:0]);
            q_ovf.push_back(m[W+1]);
         end
         if (ovalid && iready) begin
            if (q_res.size() == 0) begin
               check("rnd/spurious", 64'(ovalid), 64'd0);
            end else begin
               check("rnd/res", 64'(res), 64'(q_res.pop_front()));
               check("rnd/ovf", 64'(ovf), 64'(q_ovf.pop_front()));
            end
         end
         tick();
      end
      valid = 1'b0; iready = 1'b1;
      for (int n = 0; n < 6; n++) begin
         if (ovalid && q_res.size() != 0) begin
            check("rnd/drain_res", 64'(res), 64'(q_res.pop_front()));
            check("rnd/drain_ovf", 64'(ovf), 64'(q_ovf.pop_front()));
         end
         tick();
      end
      check("rnd/left", 64'(q_res.size()), 64'd0);

      // parameter sweep: result and exact latency for several geometries
      for (int vi = 0; vi < 6; vi++) begin
         sw_a = va[vi]; sw_b = vb[vi]; sw_cin = vc[vi]; sw_sub = vs[vi]; sw_valid = 1'b1;
         #1;
         for (int j = 0; j < 4; j++) check("sw/rdy", 64'(sw_rdy[j]), 64'd1);
         tick();
         sw_valid = 1'b0;
         for (int j = 0; j < 4; j++) begin
            seen_at[j] = 0; seen_cnt[j] = 0; got_r[j] = '0; got_o[j] = 1'b0;
         end
         for (int n = 1; n <= 28; n++) begin
            for (int j = 0; j < 4; j++) begin
               if (sw_v[j]) begin
                  if (seen_cnt[j] == 0) begin
                     seen_at[j] = n;
                     if (j == 3) got_r[j] = {18'b0, r8};
                     else        got_r[j] = sw_r[j];
                     got_o[j] = sw_o[j];
                  end
                  seen_cnt[j]++;
               end
            end
            tick();
         end
         for (int j = 0; j < 4; j++) begin
            m = model((j == 3) ? 8 : W, 32'(va[vi]), 32'(vb[vi]), vc[vi], vs[vi]);
            check("sw/latency", 64'(seen_at[j]), 64'(stg[j]));
            check("sw/count", 64'(seen_cnt[j]), 64'd1);
            check("sw/res", 64'(got_r[j]), 64'(m[W:0]));
            check("sw/ovf", 64'(got_o[j]), 64'(m[W+1]));
         end
         $display("[TB] sweep vector %0d a=%h b=%h cin=%b sub=%b", vi, va[vi], vb[vi], vc[vi], vs[vi]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
